dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the core's load/store port: accepts one request per handshake
//  (address from ALUResult, store data from WriteData) and returns ReadData plus status.
//  Replaces the zero-latency combinational dmem so the datapath can run against
//  multi-cycle memory. Backed by an internal word array with programmable wait states.
// PARAMETERS
//  DEPTH        64  number of 32-bit words; must be a power of 2, >= 2
//  WAIT_STATES  2   idle cycles between accept and response; 0..15
//  BASE_ADDR    0   byte address of word 0; must be DEPTH*4 aligned
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   synchronous reset, active-low (asserted when 0)
//  req_valid  in   1   core presents a request
//  req_ready  out  1   responder can accept a request this cycle
//  req_write  in   1   1 = store, 0 = load
//  req_byte   in   1   1 = byte access (LDRB/STRB), 0 = word access
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data; byte stores use [7:0]
//  rsp_valid  out  1   one-cycle pulse: response available
//  rsp_rdata  out  32  load data, valid while rsp_valid=1; 0 for stores and errors
//  rsp_err    out  1   valid while rsp_valid=1: out-of-range or misaligned access
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0,
//   rsp_err=0, wait counter=0. Memory contents are not cleared.
//  Reset mid-operation: the in-flight request is dropped with no response. A store is
//   committed only in RESP, so a store aborted before RESP leaves memory unchanged.
//  FSM:
//   IDLE : req_ready=1. If req_valid: latch write/byte/addr/wdata, cnt<=WAIT_STATES.
//          Go to WAIT if WAIT_STATES>0, else to RESP.
//   WAIT : req_ready=0, cnt<=cnt-1. When cnt==1, go to RESP.
//   RESP : rsp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in this cycle.
//  Latency: accept edge to rsp_valid high = WAIT_STATES+1 cycles.
//   Back-to-back requests are separated by at least WAIT_STATES+2 cycles.
//  Inputs are ignored outside IDLE; the core holds req_* until it samples req_ready=1.
//  There is no response backpressure: the core must consume rsp_* in the pulse cycle.
//  Address decode: off = addr-BASE_ADDR (modulo 2^32). Index = off[log2(DEPTH)+1:2].
//  Error conditions, checked at accept:
//   - off >= DEPTH*4 (out of range), including wrap below BASE_ADDR;
//   - word access with addr[1:0] != 0 (misaligned).
//   An errored store writes nothing. An errored load returns rsp_rdata=0.
//  Word load returns mem[idx]. Word store writes mem[idx]=wdata in the RESP cycle.
//  Byte lane = addr[1:0], little-endian: lane 0 = bits [7:0].
//  A load in the RESP cycle observes all prior committed stores.
// CONFIGURATION
//  DMEM_BYTE_ACCESS_EN defined:
//   - Byte load returns {24'b0, mem[idx][8*lane+:8]}.
//   - Byte store replaces only that lane with wdata[7:0].
//   - Byte accesses are never misaligned.
//  DMEM_BYTE_ACCESS_EN undefined:
//   - req_byte is ignored for data. Any request with req_byte=1 completes with rsp_err=1,
//     rsp_rdata=0 and no memory write, after the same latency.
// TESTING
//  T1 reset: hold reset=0 for 3 cycles, then release
//     -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//  T2 word store 0xDEADBEEF to 0x10, then word load 0x10 (WAIT_STATES=2)
//     -> each rsp_valid arrives 3 cycles after accept; load rdata=0xDEADBEEF, err=0.
//  T3 with DMEM_BYTE_ACCESS_EN: byte store 0xAA to 0x11 over word 0x11223344
//     -> word load 0x10 returns 0x1122AA44; byte load 0x13 returns 0x00000011.
//  T4 out of range and misaligned:
//     load 0x100 with DEPTH=64 -> err=1, rdata=0;
//     word store to 0x02 -> err=1, word at 0x00 unchanged.
//  T5 reset mid-store: assert reset in the WAIT cycle of a store 0x5 to 0x20
//     -> no rsp_valid; a following load of 0x20 returns the old value.
//  T6 WAIT_STATES=0, req_valid held high with 3 loads
//     -> rsp_valid pulses on every second cycle; req_ready alternates 1,0; no request lost.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store per handshake, response WAIT_STATES+1 cycles after accept.
// No response backpressure; DMEM_BYTE_ACCESS_EN enables byte loads/stores (otherwise byte requests error).
module dmem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          r_write;
  logic          r_err;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
`ifdef DMEM_BYTE_ACCESS_EN
  logic          r_byte;
  logic [1:0]    r_lane;
`endif

  logic [31:0] mem [DEPTH];

  logic [31:0] off;
  logic        acc_err;

  // Offset is modulo 2^32, so addresses below BASE_ADDR wrap high and land out of range.
  always_comb begin
    off     = req_addr - BASE_ADDR;
    acc_err = (off[31:AW+2] != '0);
`ifdef DMEM_BYTE_ACCESS_EN
    if (!req_byte && off[1:0] != 2'b00) acc_err = 1'b1;
`else
    if (req_byte || off[1:0] != 2'b00) acc_err = 1'b1;
`endif
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = (state == RESP) && r_err;

  always_comb begin
    rsp_rdata = '0;
    if (state == RESP && !r_write && !r_err) begin
`ifdef DMEM_BYTE_ACCESS_EN
      if (r_byte) rsp_rdata = {24'b0, mem[r_idx][{r_lane, 3'b000} +: 8]};
      else        rsp_rdata = mem[r_idx];
`else
      rsp_rdata = mem[r_idx];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
`ifdef DMEM_BYTE_ACCESS_EN
      r_byte  <= 1'b0;
      r_lane  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_err   <= acc_err;
            r_idx   <= off[AW+1:2];
            r_wdata <= req_wdata;
`ifdef DMEM_BYTE_ACCESS_EN
            r_byte  <= req_byte;
            r_lane  <= off[1:0];
`endif
            cnt     <= 4'(WAIT_STATES);
            state   <= (WAIT_STATES > 0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stores commit only in RESP, so a reset during WAIT (or RESP) leaves memory untouched.
  always_ff @(posedge clk) begin
    if (reset && state == RESP && r_write && !r_err) begin
`ifdef DMEM_BYTE_ACCESS_EN
      if (r_byte) mem[r_idx][{r_lane, 3'b000} +: 8] <= r_wdata[7:0];
      else        mem[r_idx] <= r_wdata;
`else
      mem[r_idx] <= r_wdata;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: WAIT_STATES=2 instance for latency/data/error/reset,
// plus a WAIT_STATES=0 instance driven with req_valid held high.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_byte;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_valid, z_write, z_byte;
  logic [31:0] z_addr, z_wdata;
  logic        z_ready, z_rsp_valid, z_err;
  logic [31:0] z_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .WAIT_STATES(2), .BASE_ADDR(32'h0)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH(64), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_valid), .req_ready(z_ready), .req_write(z_write),
    .req_byte(z_byte), .req_addr(z_addr), .req_wdata(z_wdata),
    .rsp_valid(z_rsp_valid), .rsp_rdata(z_rdata), .rsp_err(z_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on the WAIT_STATES=2 instance; checks latency, response fields, and pulse width.
  task automatic xact(input string tag, input logic w, input logic b, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    lat = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_byte = b; req_addr = a; req_wdata = d;
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
    chk({tag, ".lat"}, 32'(lat), 32'd3);
    chk({tag, ".rdata"}, rsp_rdata, exp_rdata);
    chk({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
    @(negedge clk);
    chk({tag, ".pulse"}, {30'b0, rsp_valid, req_ready}, 32'b01);
  endtask

  logic [31:0] z_exp [6];
  int          seen;

  initial begin
    req_valid = 0; req_write = 0; req_byte = 0; req_addr = 0; req_wdata = 0;
    z_valid = 0; z_write = 0; z_byte = 0; z_addr = 0; z_wdata = 0;

    // T1 reset
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("t1.ready", 32'(req_ready), 32'd1);
    chk("t1.valid", 32'(rsp_valid), 32'd0);
    chk("t1.rdata", rsp_rdata, 32'd0);
    chk("t1.err",   32'(rsp_err), 32'd0);

    // T2 word store/load
    xact("t2.st", 1, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    xact("t2.ld", 0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);

    // T3 byte lanes
    xact("t3.st", 1, 0, 32'h10, 32'h11223344, 32'h0, 0);
`ifdef DMEM_BYTE_ACCESS_EN
    xact("t3.stb", 1, 1, 32'h11, 32'hFFFFFFAA, 32'h0, 0);
    xact("t3.ld",  0, 0, 32'h10, 32'h0, 32'h1122AA44, 0);
    xact("t3.ldb", 0, 1, 32'h13, 32'h0, 32'h00000011, 0);
    xact("t3.ldb0", 0, 1, 32'h10, 32'h0, 32'h00000044, 0);
`else
    xact("t3.stb", 1, 1, 32'h11, 32'hFFFFFFAA, 32'h0, 1);
    xact("t3.ld",  0, 0, 32'h10, 32'h0, 32'h11223344, 0);
    xact("t3.ldb", 0, 1, 32'h13, 32'h0, 32'h0, 1);
`endif

    // T4 range and alignment
    xact("t4.oor",  0, 0, 32'h100, 32'h0, 32'h0, 1);
    xact("t4.wrap", 0, 0, 32'hFFFFFFFC, 32'h0, 32'h0, 1);
    xact("t4.top.st", 1, 0, 32'hFC, 32'h0BADCAFE, 32'h0, 0);
    xact("t4.top.ld", 0, 0, 32'hFC, 32'h0, 32'h0BADCAFE, 0);
    xact("t4.st0",  1, 0, 32'h00, 32'hCAFEF00D, 32'h0, 0);
    xact("t4.mis",  1, 0, 32'h02, 32'h55555555, 32'h0, 1);
    xact("t4.ld0",  0, 0, 32'h00, 32'h0, 32'hCAFEF00D, 0);
    xact("t4.misld", 0, 0, 32'h01, 32'h0, 32'h0, 1);

    // T5 reset during WAIT of a store
    xact("t5.old", 1, 0, 32'h20, 32'h00000077, 32'h0, 0);
    @(negedge clk);
    req_valid = 1; req_write = 1; req_byte = 0; req_addr = 32'h20; req_wdata = 32'h5;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("t5.norsp", 32'(seen), 32'd0);
    xact("t5.ld", 0, 0, 32'h20, 32'h0, 32'h00000077, 0);

    // T6 zero wait states, valid held high across six requests
    z_exp[0] = 32'h0; z_exp[1] = 32'h0; z_exp[2] = 32'h0;
    z_exp[3] = 32'hA0A0A0A0; z_exp[4] = 32'hB1B1B1B1; z_exp[5] = 32'hC2C2C2C2;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      z_valid = 1'b1;
      z_write = (k < 3);
      z_byte  = 1'b0;
      z_addr  = 32'(4 * (k % 3));
      z_wdata = (k == 0) ? 32'hA0A0A0A0 : (k == 1) ? 32'hB1B1B1B1 : 32'hC2C2C2C2;
      chk($sformatf("t6.%0d.idle", k), {30'b0, z_ready, z_rsp_valid}, 32'b10);
      @(negedge clk);
      chk($sformatf("t6.%0d.resp", k), {30'b0, z_ready, z_rsp_valid}, 32'b01);
      chk($sformatf("t6.%0d.rdata", k), z_rdata, z_exp[k]);
      chk($sformatf("t6.%0d.err", k), 32'(z_err), 32'd0);
      if (k < 5) @(negedge clk);
    end
    z_valid = 1'b0;
    @(negedge clk);
    chk("t6.end", {30'b0, z_ready, z_rsp_valid}, 32'b10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
